// File: rtl/pcs_pkg.sv
// Shared types for the power clock sequencer: segment codes, FSM states and
// the quarter-offset to segment mapping used by every rail.
package pcs_pkg;

    typedef enum logic [1:0] {
        SEG_LO   = 2'b00,
        SEG_RISE = 2'b01,
        SEG_HI   = 2'b10,
        SEG_FALL = 2'b11
    } seg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // idx is how many quarters a rail lags the current quarter.
    function automatic seg_t seg_of(input logic [1:0] idx);
        case (idx)
            2'd0:    seg_of = SEG_RISE;
            2'd1:    seg_of = SEG_HI;
            2'd2:    seg_of = SEG_FALL;
            default: seg_of = SEG_LO;
        endcase
    endfunction

endpackage

// File: rtl/pcs_pd_sync.sv
// Two-flop synchronizer for the phasedetector outputs; resets to all ones,
// which corresponds to every rail sitting low.
module pcs_pd_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/power_clock_sequencer.sv
// Four-phase trapezoidal power clock sequencer with staggered start-up and drain.
// Define PCS_PD_CHECK_EN to cross-check rails against the phasedetector inputs.
module power_clock_sequencer
    import pcs_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run_i,
    input  logic                    fault_clr_i,
    input  logic [NUM_PHASES-1:0]   pd_i,
    output logic [2*NUM_PHASES-1:0] seg_o,
    output logic                    busy_o,
    output logic                    fault_o,
    output logic [1:0]              quarter_o,
    output logic                    qtick_o,
    output logic [CNT_W-1:0]        period_cnt_o
);

    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    state_t                state, state_n;
    logic [1:0]            q, q_n;
    logic [STEP_W-1:0]     step, step_n;
    logic [NUM_PHASES-1:0] active, active_n;
    logic [CNT_W-1:0]      period_cnt;
    logic                  qtick;
    logic                  mismatch;

    assign busy_o       = (state == ST_RUN) || (state == ST_DRAIN);
    assign qtick        = busy_o && (step == STEP_LAST);
    assign qtick_o      = qtick;
    assign quarter_o    = q;
    assign period_cnt_o = period_cnt;

    always_comb begin
        seg_o = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (active[k]) seg_o[2*k +: 2] = seg_of(q - 2'(k));
        end
    end

`ifdef PCS_PD_CHECK_EN
    logic [NUM_PHASES-1:0] pd_sync;

    pcs_pd_sync #(.WIDTH(NUM_PHASES)) u_pd_sync (
        .clk (clk),
        .rst (rst),
        .d   (pd_i),
        .q   (pd_sync)
    );

    // A rail must read high (pd=0) at the end of HI and low (pd=1) at the end of LO.
    always_comb begin
        mismatch = 1'b0;
        if (qtick) begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                if (active[k] && (seg_of(q - 2'(k)) == SEG_HI) && pd_sync[k])
                    mismatch = 1'b1;
                if (active[k] && (seg_of(q - 2'(k)) == SEG_LO) && !pd_sync[k])
                    mismatch = 1'b1;
            end
        end
    end

    assign fault_o = (state == ST_FAULT);
`else
    logic unused_pd;
    assign unused_pd = ^pd_i;
    assign mismatch  = 1'b0;
    assign fault_o   = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        q_n      = q;
        step_n   = step;
        active_n = active;
        case (state)
            ST_IDLE: begin
                q_n      = 2'd0;
                step_n   = '0;
                active_n = '0;
                if (run_i) begin
                    state_n     = ST_RUN;
                    active_n[0] = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (qtick) begin
                    step_n = '0;
                    q_n    = q + 2'd1;
                    // RUN arms rail k entering q=k; DRAIN retires it entering its LO.
                    for (int k = 0; k < NUM_PHASES; k++) begin
                        if ((state == ST_RUN) && (q_n == 2'(k)))
                            active_n[k] = 1'b1;
                        else if ((state == ST_DRAIN) && ((q_n - 2'(k)) == 2'd3))
                            active_n[k] = 1'b0;
                    end
                end else begin
                    step_n = step + 1'b1;
                end
                if (state == ST_RUN) begin
                    if (!run_i) state_n = ST_DRAIN;
                end else if (active == '0) begin
                    state_n = ST_IDLE;
                    q_n     = 2'd0;
                    step_n  = '0;
                end else if (run_i) begin
                    state_n = ST_RUN;
                end
                if (mismatch) begin
                    state_n  = ST_FAULT;
                    active_n = '0;
                    q_n      = 2'd0;
                    step_n   = '0;
                end
            end
            default: begin
                q_n      = 2'd0;
                step_n   = '0;
                active_n = '0;
                if (fault_clr_i && !run_i) state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            q      <= 2'd0;
            step   <= '0;
            active <= '0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            step   <= step_n;
            active <= active_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if (qtick && (q == 2'd3))
            period_cnt <= period_cnt + 1'b1;
    end

endmodule

// File: tb/tb_power_clock_sequencer.sv
// Directed bench for power_clock_sequencer (STEP_CYCLES=4): start-up stagger,
// drain, drain-abort re-arm, phasedetector fault and asynchronous reset.
module tb_power_clock_sequencer;

    logic        clk;
    logic        rst;
    logic        run_i;
    logic        fault_clr_i;
    logic [3:0]  pd_i;
    logic [7:0]  seg_o;
    logic        busy_o;
    logic        fault_o;
    logic [1:0]  quarter_o;
    logic        qtick_o;
    logic [15:0] period_cnt_o;

    logic [3:0]  force_mask;
    int          n_cmp;
    int          n_err;
    logic        qtick_seen;

    power_clock_sequencer #(
        .NUM_PHASES  (4),
        .STEP_CYCLES (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .fault_clr_i  (fault_clr_i),
        .pd_i         (pd_i),
        .seg_o        (seg_o),
        .busy_o       (busy_o),
        .fault_o      (fault_o),
        .quarter_o    (quarter_o),
        .qtick_o      (qtick_o),
        .period_cnt_o (period_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Phasedetector model: pd = inverted rail level, rail high only in HI.
    initial begin
        pd_i = 4'hF;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 4; k++)
                pd_i[k] = (seg_o[2*k +: 2] != 2'b10) | force_mask[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        run_i       = 1'b0;
        fault_clr_i = 1'b0;
        force_mask  = 4'h0;
        qtick_seen  = 1'b0;
        #12 rst = 1'b0;
        #1;
        check("rst_seg",    32'(seg_o), 32'h00);
        check("rst_busy",   32'(busy_o), 32'd0);
        check("rst_fault",  32'(fault_o), 32'd0);
        check("rst_qtick",  32'(qtick_o), 32'd0);
        check("rst_period", 32'(period_cnt_o), 32'd0);
        check("rst_quarter", 32'(quarter_o), 32'd0);

        for (int i = 0; i < 20; i++) begin
            step_clk(1);
            check("idle_seg",  32'(seg_o), 32'h00);
            check("idle_busy", 32'(busy_o), 32'd0);
            if (qtick_o) qtick_seen = 1'b1;
        end
        check("idle_qtick_never", 32'(qtick_seen), 32'd0);
        check("idle_period", 32'(period_cnt_o), 32'd0);

        // Start-up stagger
        run_i = 1'b1;
        step_clk(1);
        check("up1_seg",  32'(seg_o), 32'h01);
        check("up1_busy", 32'(busy_o), 32'd1);
        check("up1_q",    32'(quarter_o), 32'd0);
        step_clk(2);
        check("up3_qtick", 32'(qtick_o), 32'd0);
        step_clk(1);
        check("up4_qtick", 32'(qtick_o), 32'd1);
        step_clk(1);
        check("up5_seg", 32'(seg_o), 32'h06);
        check("up5_q",   32'(quarter_o), 32'd1);
        step_clk(4);
        check("up9_seg", 32'(seg_o), 32'h1B);
        check("up9_q",   32'(quarter_o), 32'd2);
        step_clk(4);
        check("up13_seg", 32'(seg_o), 32'h6C);
        step_clk(3);
        check("up16_period", 32'(period_cnt_o), 32'd0);
        step_clk(1);
        check("up17_seg",    32'(seg_o), 32'hB1);
        check("up17_period", 32'(period_cnt_o), 32'd1);
        check("up17_q",      32'(quarter_o), 32'd0);

        // Drain requested at q=2
        step_clk(8);
        check("dr25_q", 32'(quarter_o), 32'd2);
        run_i = 1'b0;
        step_clk(1);
        check("dr26_busy", 32'(busy_o), 32'd1);
        step_clk(3);
        check("dr29_seg", 32'(seg_o), 32'h6C);
        step_clk(4);
        check("dr33_seg",    32'(seg_o), 32'hB0);
        check("dr33_period", 32'(period_cnt_o), 32'd2);
        step_clk(4);
        check("dr37_seg", 32'(seg_o), 32'hC0);
        step_clk(4);
        check("dr41_seg",  32'(seg_o), 32'h00);
        check("dr41_busy", 32'(busy_o), 32'd1);
        step_clk(1);
        check("dr42_busy",   32'(busy_o), 32'd0);
        check("dr42_q",      32'(quarter_o), 32'd0);
        check("dr42_period", 32'(period_cnt_o), 32'd2);

        // Restart, drain, then abort the drain at q=1
        run_i = 1'b1;
        step_clk(1);
        check("re1_seg", 32'(seg_o), 32'h01);
        step_clk(16);
        check("re17_seg",    32'(seg_o), 32'hB1);
        check("re17_period", 32'(period_cnt_o), 32'd3);
        run_i = 1'b0;
        step_clk(4);
        check("re21_seg",  32'(seg_o), 32'hC6);
        check("re21_busy", 32'(busy_o), 32'd1);
        run_i = 1'b1;
        step_clk(1);
        check("re22_busy", 32'(busy_o), 32'd1);
        step_clk(3);
        check("re25_seg", 32'(seg_o), 32'h1B);

        // Phase 2 rail fails to rise during its HI
        step_clk(4);
        check("ft29_seg", 32'(seg_o), 32'h6C);
        force_mask = 4'b0100;
        step_clk(4);
`ifdef PCS_PD_CHECK_EN
        check("ft33_seg",   32'(seg_o), 32'h00);
        check("ft33_fault", 32'(fault_o), 32'd1);
        check("ft33_busy",  32'(busy_o), 32'd0);
`else
        check("ft33_seg",   32'(seg_o), 32'hB1);
        check("ft33_fault", 32'(fault_o), 32'd0);
        check("ft33_busy",  32'(busy_o), 32'd1);
`endif
        force_mask  = 4'h0;
        fault_clr_i = 1'b1;
        step_clk(2);
`ifdef PCS_PD_CHECK_EN
        check("ft35_clr_ignored", 32'(fault_o), 32'd1);
`else
        check("ft35_fault", 32'(fault_o), 32'd0);
`endif
        run_i = 1'b0;
        step_clk(1);
        check("ft36_fault", 32'(fault_o), 32'd0);
`ifdef PCS_PD_CHECK_EN
        check("ft36_busy", 32'(busy_o), 32'd0);
`else
        check("ft36_busy", 32'(busy_o), 32'd1);
`endif
        fault_clr_i = 1'b0;

        // Asynchronous reset mid-operation
        step_clk(1);
        rst = 1'b1;
        #1;
        check("arst_seg",    32'(seg_o), 32'h00);
        check("arst_busy",   32'(busy_o), 32'd0);
        check("arst_period", 32'(period_cnt_o), 32'd0);
        check("arst_q",      32'(quarter_o), 32'd0);
        check("arst_fault",  32'(fault_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
